// File: rtl/seg_display_ctrl_pkg.sv
// Register map and CTRL bit positions for the dual 7-segment display controller.
// Firmware headers mirror these values.
package seg_display_ctrl_pkg;

   // Word offsets (mem_addr[3:2] of the byte address)
   typedef enum logic [1:0] {
      REG_DATA = 2'd0,
      REG_CTRL = 2'd1,
      REG_CNT  = 2'd2,
      REG_STAT = 2'd3
   } reg_addr_e;

   // CTRL register bit positions
   localparam int unsigned CTRL_EN1      = 0;
   localparam int unsigned CTRL_EN2      = 1;
   localparam int unsigned CTRL_BLK1     = 2;
   localparam int unsigned CTRL_BLK2     = 3;
   localparam int unsigned CTRL_RATE_LSB = 4;
   localparam int unsigned CTRL_RATE_MSB = 7;
   localparam int unsigned CTRL_AUTO     = 8;
   localparam int unsigned CTRL_W        = 9;

   // STAT register field positions
   localparam int unsigned STAT_PHASE   = 0;
   localparam int unsigned STAT_CNT_LSB = 8;

endpackage

// File: rtl/seg_display_ctrl_tick_gen.sv
// Prescaler: emits a one-cycle tick every PRESCALE clock cycles.
module seg_tick_gen #(
   parameter int unsigned PRESCALE = 1_200_000,
   parameter int unsigned CNT_W    = 21
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] pcnt;

   // Free-running 0..PRESCALE-1 counter
   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt <= '0;
      end else if (pcnt == LAST) begin
         pcnt <= '0;
      end else begin
         pcnt <= pcnt + 1'b1;
      end
   end

   // Tick on the last count of each period
   always_comb begin
      tick = (pcnt == LAST);
   end

endmodule

// File: rtl/seg_display_ctrl.sv
// Memory-mapped dual 7-segment display controller on the PicoRV32 native bus.
// Holds digit codes, enables and blink settings; runs an optional hex counter.
import seg_display_ctrl_pkg::*;

module seg_display_ctrl #(
   parameter int unsigned PRESCALE = 1_200_000,
   parameter int unsigned CNT_W    = 21
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sel,
   input  logic        mem_valid,
   input  logic [1:0]  mem_addr,
   input  logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_ready,
   output logic        disable1,
   output logic        disable2,
   output logic [4:0]  seg_data_1,
   output logic [4:0]  seg_data_2
);

   logic [4:0]        d1;
   logic [4:0]        d2;
   logic [CTRL_W-1:0] ctrl;
   logic [7:0]        cnt;
   logic              phase;
   logic [3:0]        scnt;

   logic              tick;
   logic              accept;
   logic              wr;
   logic              rd;
   logic              ctrl_wr;
   logic              step;
   logic [3:0]        rate;
   logic              auto_mode;
   reg_addr_e         addr;
   logic [31:0]       rdval;

   seg_tick_gen #(
      .PRESCALE(PRESCALE),
      .CNT_W   (CNT_W)
   ) u_tick (
      .clk (clk),
      .rst (rst),
      .tick(tick)
   );

   // Request decode, step detection and read-data mux
   always_comb begin
      addr      = reg_addr_e'(mem_addr);
      accept    = sel & mem_valid & ~mem_ready;
      wr        = accept & (|mem_wstrb);
      rd        = accept & ~(|mem_wstrb);
      ctrl_wr   = wr & (addr == REG_CTRL);
      rate      = ctrl[CTRL_RATE_MSB:CTRL_RATE_LSB];
      auto_mode = ctrl[CTRL_AUTO];
      step      = tick & (scnt == rate);
      rdval     = '0;
      case (addr)
         REG_DATA: rdval = {19'b0, d2, 3'b0, d1};
         REG_CTRL: rdval = {23'b0, ctrl};
         REG_CNT:  rdval = {24'b0, cnt};
         REG_STAT: rdval = {16'b0, cnt, 7'b0, phase};
         default:  rdval = '0;
      endcase
   end

   // Bus handshake: single-cycle ready pulse with registered read data
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_ready <= 1'b0;
         mem_rdata <= '0;
      end else begin
         mem_ready <= accept;
         mem_rdata <= rd ? rdval : '0;
      end
   end

   // DATA and CTRL registers, byte-strobe qualified
   always_ff @(posedge clk) begin
      if (rst) begin
         d1   <= '0;
         d2   <= '0;
         ctrl <= '0;
      end else if (wr) begin
         if (addr == REG_DATA) begin
            if (mem_wstrb[0]) d1 <= mem_wdata[4:0];
            if (mem_wstrb[1]) d2 <= mem_wdata[12:8];
         end
         if (addr == REG_CTRL) begin
            if (mem_wstrb[0]) ctrl[7:0] <= mem_wdata[7:0];
            if (mem_wstrb[1]) ctrl[8]   <= mem_wdata[8];
         end
      end
   end

   // Step divider, blink phase and hardware counter; a CNT write beats an increment
   always_ff @(posedge clk) begin
      if (rst) begin
         scnt  <= '0;
         phase <= 1'b0;
         cnt   <= '0;
      end else begin
         if (ctrl_wr) begin
            scnt <= '0;
         end else if (tick) begin
            scnt <= step ? 4'd0 : scnt + 4'd1;
         end
         if (step) begin
            phase <= ~phase;
         end
         if (wr && (addr == REG_CNT) && mem_wstrb[0]) begin
            cnt <= mem_wdata[7:0];
         end else if (step && auto_mode) begin
            cnt <= cnt + 8'd1;
         end
      end
   end

   // Registered output mux feeding the segment decoder
   always_ff @(posedge clk) begin
      if (rst) begin
         disable1   <= 1'b1;
         disable2   <= 1'b1;
         seg_data_1 <= '0;
         seg_data_2 <= '0;
      end else begin
         disable1   <= ~ctrl[CTRL_EN1] | (ctrl[CTRL_BLK1] & phase);
         disable2   <= ~ctrl[CTRL_EN2] | (ctrl[CTRL_BLK2] & phase);
         seg_data_1 <= auto_mode ? {1'b0, cnt[3:0]} : d1;
         seg_data_2 <= auto_mode ? {1'b0, cnt[7:4]} : d2;
      end
   end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl with a cycle-level behavioural model.
module tb_seg_display_ctrl;

   localparam int unsigned P = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sel = 1'b0;
   logic        mem_valid = 1'b0;
   logic [1:0]  mem_addr = '0;
   logic [3:0]  mem_wstrb = '0;
   logic [31:0] mem_wdata = '0;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        disable1;
   logic        disable2;
   logic [4:0]  seg_data_1;
   logic [4:0]  seg_data_2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seg_display_ctrl #(
      .PRESCALE(P),
      .CNT_W   (3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sel       (sel),
      .mem_valid (mem_valid),
      .mem_addr  (mem_addr),
      .mem_wstrb (mem_wstrb),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .disable1  (disable1),
      .disable2  (disable2),
      .seg_data_1(seg_data_1),
      .seg_data_2(seg_data_2)
   );

   // ---------------- reference model ----------------
   logic [31:0] m_data, m_ctrl, m_cnt;
   logic        m_phase;
   int unsigned m_ticks, m_cyc;
   logic        e_ready;
   logic [31:0] e_rdata;
   logic        e_dis1, e_dis2;
   logic [4:0]  e_seg1, e_seg2;

   function automatic logic [31:0] strb_mask(input logic [3:0] s);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < 4; i++) if (s[i]) m[i*8 +: 8] = 8'hFF;
      return m;
   endfunction

   task model_step;
      logic        acc, tk, stp;
      logic [31:0] mask;
      int unsigned rate;
      if (rst) begin
         m_data = '0; m_ctrl = '0; m_cnt = '0; m_phase = 1'b0;
         m_ticks = 0; m_cyc = 0;
         e_ready = 1'b0; e_rdata = '0;
         e_dis1 = 1'b1; e_dis2 = 1'b1; e_seg1 = '0; e_seg2 = '0;
      end else begin
         e_seg1 = m_ctrl[8] ? {1'b0, m_cnt[3:0]} : m_data[4:0];
         e_seg2 = m_ctrl[8] ? {1'b0, m_cnt[7:4]} : m_data[12:8];
         e_dis1 = !m_ctrl[0] || (m_ctrl[2] && m_phase);
         e_dis2 = !m_ctrl[1] || (m_ctrl[3] && m_phase);
         acc = sel && mem_valid && !e_ready;
         e_rdata = '0;
         if (acc && mem_wstrb == 4'h0) begin
            case (mem_addr)
               2'd0: e_rdata = m_data;
               2'd1: e_rdata = m_ctrl;
               2'd2: e_rdata = m_cnt;
               default: e_rdata = {16'b0, m_cnt[7:0], 7'b0, m_phase};
            endcase
         end
         e_ready = acc;
         rate = {28'b0, m_ctrl[7:4]};
         tk = (m_cyc % P) == P - 1;
         m_cyc++;
         stp = 1'b0;
         if (tk) begin
            m_ticks++;
            if (m_ticks == rate + 1) begin
               stp = 1'b1;
               m_ticks = 0;
            end
         end
         if (stp) begin
            m_phase = !m_phase;
            if (m_ctrl[8]) m_cnt = (m_cnt + 1) % 256;
         end
         if (acc && mem_wstrb != 4'h0) begin
            mask = strb_mask(mem_wstrb);
            case (mem_addr)
               2'd0: m_data = ((m_data & ~mask) | (mem_wdata & mask)) & 32'h0000_1F1F;
               2'd1: begin
                  m_ctrl  = ((m_ctrl & ~mask) | (mem_wdata & mask)) & 32'h0000_01FF;
                  m_ticks = 0;
               end
               2'd2: m_cnt = ((m_cnt & ~mask) | (mem_wdata & mask)) & 32'h0000_00FF;
               default: ;
            endcase
         end
      end
   endtask

   always @(posedge clk) model_step();

   // ---------------- bus helper (called at a negedge) ----------------
   task automatic bus_xfer(input logic [1:0] a, input logic [31:0] wd, input logic [3:0] st,
                           output logic [31:0] rdat, output int lat);
      @(negedge clk);
      sel = 1'b1; mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = st;
      lat = 0; rdat = '0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (mem_ready === 1'b1) begin
            lat = i;
            rdat = mem_rdata;
            break;
         end
      end
      sel = 1'b0; mem_valid = 1'b0; mem_wstrb = '0;
      checks++;
      if (lat == 0) begin
         errors++;
         $display("FAIL bus_timeout addr=%0d got no mem_ready want ready within 8 cycles", a);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      logic [31:0] r;
      int          lat;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (disable1 !== 1'b1) begin errors++; $display("FAIL reset_dis1 got %b want 1", disable1); end
      checks++; if (disable2 !== 1'b1) begin errors++; $display("FAIL reset_dis2 got %b want 1", disable2); end
      checks++; if (seg_data_1 !== 5'h0) begin errors++; $display("FAIL reset_seg1 got %h want 00", seg_data_1); end
      checks++; if (seg_data_2 !== 5'h0) begin errors++; $display("FAIL reset_seg2 got %h want 00", seg_data_2); end
      checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", mem_ready); end
      checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", mem_rdata); end
      rst = 1'b0;
      bus_xfer(2'd3, 32'h0, 4'h0, r, lat);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_stat got %h want 00000000", r); end
   endtask

   task automatic test_data_rw;
      logic [31:0] r;
      int          lat;
      bus_xfer(2'd0, 32'h0000_1A05, 4'hF, r, lat);
      bus_xfer(2'd1, 32'h0000_0003, 4'hF, r, lat);
      @(negedge clk);
      checks++; if (seg_data_1 !== 5'h05) begin errors++; $display("FAIL data_seg1 got %h want 05", seg_data_1); end
      checks++; if (seg_data_2 !== 5'h1A) begin errors++; $display("FAIL data_seg2 got %h want 1a", seg_data_2); end
      checks++; if (disable1 !== 1'b0) begin errors++; $display("FAIL data_dis1 got %b want 0", disable1); end
      checks++; if (disable2 !== 1'b0) begin errors++; $display("FAIL data_dis2 got %b want 0", disable2); end
      bus_xfer(2'd0, 32'h0, 4'h0, r, lat);
      checks++; if (r !== 32'h0000_1A05) begin errors++; $display("FAIL data_read got %h want 00001a05", r); end
      checks++; if (lat != 1) begin errors++; $display("FAIL data_latency got %0d want 1", lat); end
      bus_xfer(2'd0, 32'hFFFF_FFFF, 4'h1, r, lat);
      bus_xfer(2'd0, 32'h0, 4'h0, r, lat);
      checks++; if (r !== 32'h0000_1A1F) begin errors++; $display("FAIL partial_write got %h want 00001a1f", r); end
      bus_xfer(2'd3, 32'hFFFF_FFFF, 4'hF, r, lat);
      bus_xfer(2'd3, 32'h0, 4'h0, r, lat);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL stat_ro got %h want 00000000", r); end
   endtask

   task automatic test_auto_count;
      logic [31:0] r;
      int          lat;
      logic [7:0]  v, prev;
      logic        pd, saw_wrap;
      int          last_toggle;
      int          n_inc_err, n_tog_err;
      bus_xfer(2'd1, 32'h0000_0107, 4'hF, r, lat);
      @(negedge clk);
      saw_wrap = 1'b0; n_inc_err = 0; n_tog_err = 0; last_toggle = -1;
      prev = {seg_data_2[3:0], seg_data_1[3:0]};
      pd = disable1;
      for (int i = 0; i < 1100; i++) begin
         @(negedge clk);
         checks++;
         if (seg_data_1 !== e_seg1 || seg_data_2 !== e_seg2 || disable1 !== e_dis1 || disable2 !== e_dis2) begin
            errors++;
            $display("FAIL auto_model cyc=%0d got s1=%h s2=%h d1=%b d2=%b want s1=%h s2=%h d1=%b d2=%b",
                     i, seg_data_1, seg_data_2, disable1, disable2, e_seg1, e_seg2, e_dis1, e_dis2);
         end
         v = {seg_data_2[3:0], seg_data_1[3:0]};
         if (v != prev) begin
            if (v != prev + 8'd1) n_inc_err++;
            if (prev == 8'hFF && v == 8'h00) saw_wrap = 1'b1;
            prev = v;
         end
         if (disable1 != pd) begin
            if (last_toggle >= 0 && (i - last_toggle) != 4) n_tog_err++;
            last_toggle = i;
            pd = disable1;
         end
      end
      checks++; if (n_inc_err != 0) begin errors++; $display("FAIL auto_increment got %0d bad steps want 0", n_inc_err); end
      checks++; if (!saw_wrap) begin errors++; $display("FAIL auto_wrap got no FF->00 want wrap"); end
      checks++; if (n_tog_err != 0) begin errors++; $display("FAIL phase_period got %0d bad intervals want 0", n_tog_err); end
      checks++; if (seg_data_1[4] !== 1'b0 || seg_data_2[4] !== 1'b0) begin
         errors++; $display("FAIL auto_dp got %b%b want 00", seg_data_1[4], seg_data_2[4]);
      end
   endtask

   task automatic test_cnt_collision;
      logic [31:0] r;
      int          lat;
      logic        d0;
      int          first;
      // Align a CNT write with an edge on which a step occurs
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if ((m_cyc % P) == P - 1 && m_ticks == 0 && !e_ready) break;
      end
      checks++;
      if (!((m_cyc % P) == P - 1 && m_ticks == 0)) begin
         errors++; $display("FAIL collision_align got no step slot want step slot");
      end
      sel = 1'b1; mem_valid = 1'b1; mem_addr = 2'd2; mem_wdata = 32'h42; mem_wstrb = 4'hF;
      @(negedge clk);
      sel = 1'b0; mem_valid = 1'b0; mem_wstrb = '0;
      checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL collision_ready got %b want 1", mem_ready); end
      @(negedge clk);
      checks++; if (seg_data_1 !== 5'h02) begin errors++; $display("FAIL collision_lo got %h want 02", seg_data_1); end
      checks++; if (seg_data_2 !== 5'h04) begin errors++; $display("FAIL collision_hi got %h want 04", seg_data_2); end
      // Rate change: write CTRL two cycles after a tick edge
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if ((m_cyc % P) == 1 && !e_ready) break;
      end
      sel = 1'b1; mem_valid = 1'b1; mem_addr = 2'd1; mem_wdata = 32'h0000_0137; mem_wstrb = 4'hF;
      @(negedge clk);
      sel = 1'b0; mem_valid = 1'b0; mem_wstrb = '0;
      d0 = disable1;
      first = 0;
      for (int j = 1; j <= 24; j++) begin
         @(negedge clk);
         checks++;
         if (disable1 !== e_dis1) begin
            errors++; $display("FAIL rate_model j=%0d got %b want %b", j, disable1, e_dis1);
         end
         if (first == 0 && disable1 != d0) first = j;
      end
      checks++; if (first != 15) begin errors++; $display("FAIL rate_step_delay got %0d want 15", first); end
      bus_xfer(2'd2, 32'h0, 4'h0, r, lat);
      checks++; if (r !== e_rdata && r !== m_cnt) begin errors++; $display("FAIL cnt_read got %h want %h", r, m_cnt); end
   endtask

   task automatic test_back_to_back;
      logic        pat [5];
      logic        want [5];
      logic [31:0] r;
      int          lat;
      want = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      @(negedge clk);
      @(negedge clk);
      sel = 1'b1; mem_valid = 1'b1; mem_addr = 2'd0; mem_wstrb = 4'h0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         pat[i] = mem_ready;
         checks++;
         if (pat[i] !== want[i]) begin
            errors++; $display("FAIL b2b_ready[%0d] got %b want %b", i, pat[i], want[i]);
         end
         checks++;
         if (mem_rdata !== e_rdata) begin
            errors++; $display("FAIL b2b_rdata[%0d] got %h want %h", i, mem_rdata, e_rdata);
         end
      end
      sel = 1'b0; mem_valid = 1'b0;
      // Reset lands on the edge that would have completed the request
      @(negedge clk);
      sel = 1'b1; mem_valid = 1'b1; mem_addr = 2'd0; mem_wdata = 32'h55; mem_wstrb = 4'hF; rst = 1'b1;
      @(negedge clk);
      checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL rst_drop_ready got %b want 0", mem_ready); end
      rst = 1'b0; sel = 1'b0; mem_valid = 1'b0; mem_wstrb = '0;
      @(negedge clk);
      checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL rst_after_ready got %b want 0", mem_ready); end
      checks++; if (disable1 !== 1'b1 || seg_data_1 !== 5'h0) begin
         errors++; $display("FAIL rst_outputs got d1=%b s1=%h want d1=1 s1=00", disable1, seg_data_1);
      end
      bus_xfer(2'd0, 32'h0, 4'h0, r, lat);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL rst_data got %h want 00000000", r); end
   endtask

   task automatic test_random;
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         checks++;
         if (mem_ready !== e_ready || mem_rdata !== e_rdata || seg_data_1 !== e_seg1 || seg_data_2 !== e_seg2 ||
             disable1 !== e_dis1 || disable2 !== e_dis2) begin
            errors++;
            $display("FAIL random cyc=%0d got rdy=%b rd=%h s1=%h s2=%h d=%b%b want rdy=%b rd=%h s1=%h s2=%h d=%b%b",
                     i, mem_ready, mem_rdata, seg_data_1, seg_data_2, disable1, disable2,
                     e_ready, e_rdata, e_seg1, e_seg2, e_dis1, e_dis2);
         end
         sel       = ($urandom_range(0, 3) != 0);
         mem_valid = ($urandom_range(0, 9) < 6);
         mem_addr  = 2'($urandom_range(0, 3));
         mem_wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         mem_wdata = $urandom;
         if (mem_addr == 2'd1 && mem_wstrb != 4'h0) mem_wdata[7:6] = 2'b00;
      end
      @(negedge clk);
      sel = 1'b0; mem_valid = 1'b0; mem_wstrb = '0;
   endtask

   initial begin
      test_reset();
      test_data_rw();
      test_auto_count();
      test_cnt_collision();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

endmodule
